// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO registers.
// Latency: MULT_CYCLES / DIV_CYCLES cycles of busy after accept; MTHI/MTLO commit at the accept edge.
// Backpressure: start is ignored while busy is high; there is no queueing and no error report.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   // op_q[1] = divide class, op_q[0] = unsigned variant
   logic [1:0]        op_q, op_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic              done_q, done_d;

   // Arithmetic datapath, evaluated from the captured operands
   logic [63:0] a_sx, b_sx, a_zx, b_zx;
   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag;
   logic [31:0] dvd, dvs;
   logic [31:0] udq, udr;
   logic [31:0] quo, rem;
   logic        is_signed_div;
   logic        div_by_zero;
   logic [63:0] result;

   // Product, quotient and remainder for the operation in flight
   always_comb begin
      a_sx   = {{32{a_q[31]}}, a_q};
      b_sx   = {{32{b_q[31]}}, b_q};
      a_zx   = {32'd0, a_q};
      b_zx   = {32'd0, b_q};
      // Low 64 bits of a sign-extended product equal the signed 64-bit product
      prod_s = a_sx * b_sx;
      prod_u = a_zx * b_zx;

      is_signed_div = (op_q == OP_DIV[1:0]);
      // Magnitudes as unsigned values; 0x80000000 maps onto itself, which is the correct magnitude
      a_mag = a_q[31] ? (32'd0 - a_q) : a_q;
      b_mag = b_q[31] ? (32'd0 - b_q) : b_q;
      dvd   = is_signed_div ? a_mag : a_q;
      dvs   = is_signed_div ? b_mag : b_q;
      div_by_zero = (b_q == 32'd0);

      udq = 32'd0;
      udr = 32'd0;
      if (!div_by_zero) begin
         udq = dvd / dvs;
         udr = dvd % dvs;
      end

      // Quotient truncates toward zero; remainder follows the dividend's sign
      quo = udq;
      rem = udr;
      if (is_signed_div) begin
         quo = (a_q[31] ^ b_q[31]) ? (32'd0 - udq) : udq;
         rem = a_q[31] ? (32'd0 - udr) : udr;
      end

      case (op_q)
         OP_MULT[1:0]:  result = prod_s;
         OP_MULTU[1:0]: result = prod_u;
         default:       result = {rem, quo};
      endcase
   end

   // Next-state: accept in IDLE, count down in RUN, commit HI/LO on the last busy cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (md_op)
                  OP_MULT, OP_MULTU: begin
                     state_d = S_RUN;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     op_d    = md_op[1:0];
                     a_d     = src_a;
                     b_d     = src_b;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d = S_RUN;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     op_d    = md_op[1:0];
                     a_d     = src_a;
                     b_d     = src_b;
                  end
                  OP_MTHI: hi_d = src_a;
                  OP_MTLO: lo_d = src_a;
                  // Reserved encodings leave every register untouched
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               // A zero divisor still burns the full latency but leaves HI/LO as they were
               if (!(op_q[1] && div_by_zero)) begin
                  hi_d = result[63:32];
                  lo_d = result[31:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset dominates start and discards any operation in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 2'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
